// File: rtl/tone_rom_reader_pkg.sv
// tone_rom_reader_pkg: shared widths and response record for the tone ROM reader (TONE_OCTAVE_SHIFT_EN adds the shift width use)
package tone_rom_reader_pkg;
  localparam int NOTE_W = 8;
  localparam int PHASE_W = 24;
  localparam int VOICE_W = 5;
  localparam int SHIFT_W = 3;
  localparam int FIFO_DEPTH = 4;
  typedef struct packed {
    logic [VOICE_W-1:0] voice;
    logic [PHASE_W-1:0] inc;
  } tone_rsp_t;
endpackage

// File: rtl/tone_rom_reader_if.sv
// tone_rom_reader_if: request, ROM and response signals of the reader; req_shift exists only with TONE_OCTAVE_SHIFT_EN
interface tone_rom_reader_if;
  import tone_rom_reader_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [NOTE_W-1:0] req_note;
  logic [VOICE_W-1:0] req_voice;
`ifdef TONE_OCTAVE_SHIFT_EN
  logic [SHIFT_W-1:0] req_shift;
`endif
  logic [NOTE_W-1:0] rom_addr;
  logic [PHASE_W-1:0] rom_q;
  logic rsp_valid;
  logic rsp_ready;
  logic [PHASE_W-1:0] rsp_inc;
  logic [VOICE_W-1:0] rsp_voice;
`ifdef TONE_OCTAVE_SHIFT_EN
  modport master (input req_valid, req_note, req_voice, req_shift, rom_q, rsp_ready,
                  output req_ready, rom_addr, rsp_valid, rsp_inc, rsp_voice);
  modport slave (output req_valid, req_note, req_voice, req_shift, rom_q, rsp_ready,
                 input req_ready, rom_addr, rsp_valid, rsp_inc, rsp_voice);
`else
  modport master (input req_valid, req_note, req_voice, rom_q, rsp_ready,
                  output req_ready, rom_addr, rsp_valid, rsp_inc, rsp_voice);
  modport slave (output req_valid, req_note, req_voice, rom_q, rsp_ready,
                 input req_ready, rom_addr, rsp_valid, rsp_inc, rsp_voice);
`endif
endinterface

// File: rtl/tone_rom_reader_fifo.sv
// tone_rom_reader_fifo: show-ahead sync FIFO of tone responses with wrap-bit pointers
module tone_rom_reader_fifo
  import tone_rom_reader_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  tone_rsp_t wdata,
  output tone_rsp_t rdata,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  tone_rsp_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = empty ? '0 : mem[rp[AW-1:0]];
  // pointer advance; contents are discarded on reset by clearing both pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  end
  // storage write, no reset needed since reads are masked while empty
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/tone_rom_reader.sv
// tone_rom_reader: ROM read initiator with 2-stage latency tracking and credit-protected response FIFO (TONE_OCTAVE_SHIFT_EN: per-request octave shift)
module tone_rom_reader
  import tone_rom_reader_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input logic clk,
  input logic reset,
  tone_rom_reader_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] used;
  logic accept, pop, push, full, empty;
  logic s1_valid, s2_valid;
  logic [VOICE_W-1:0] s1_voice, s2_voice;
  logic [PHASE_W-1:0] inc;
  tone_rsp_t head;
  assign accept = bus.req_valid && bus.req_ready;
  assign pop = bus.rsp_valid && bus.rsp_ready;
  assign push = s2_valid && (!full || pop);
  assign bus.req_ready = !reset && (used < CW'(DEPTH));
  assign bus.rsp_valid = !empty;
  assign bus.rsp_inc = head.inc;
  assign bus.rsp_voice = head.voice;
`ifdef TONE_OCTAVE_SHIFT_EN
  logic [SHIFT_W-1:0] s1_shift, s2_shift;
  assign inc = bus.rom_q >> s2_shift;
  // shift travels alongside the voice tag to line up with the ROM data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_shift <= '0;
      s2_shift <= '0;
    end else begin
      s1_shift <= accept ? bus.req_shift : s1_shift;
      s2_shift <= s1_shift;
    end
  end
`else
  assign inc = bus.rom_q;
`endif
  // credits cover every slot reserved from accept until the response is popped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) used <= '0;
    else used <= used + CW'(accept) - CW'(pop);
  end
  // address is only updated on accept so the ROM input never toggles idly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_voice <= '0;
      s2_valid <= 1'b0;
      s2_voice <= '0;
    end else begin
      bus.rom_addr <= accept ? bus.req_note : bus.rom_addr;
      s1_valid <= accept;
      s1_voice <= accept ? bus.req_voice : s1_voice;
      s2_valid <= s1_valid;
      s2_voice <= s1_voice;
    end
  end
  tone_rom_reader_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata('{voice: s2_voice, inc: inc}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_tone_rom_reader.sv
// tb_tone_rom_reader: directed and random checks of the tone ROM reader against a transaction-level model (TONE_OCTAVE_SHIFT_EN aware)
module tb_tone_rom_reader;
  import tone_rom_reader_pkg::*;
  typedef struct {
    logic [PHASE_W-1:0] inc;
    logic [VOICE_W-1:0] voice;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [PHASE_W-1:0] rom [256];
  exp_t q[$];
  int cyc_n = 0;
  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int rsp_seen = 0;
  logic [NOTE_W-1:0] last_note = '0;
  always #5 clk = ~clk;
  tone_rom_reader_if bus();
  tone_rom_reader dut (.clk(clk), .reset(reset), .bus(bus));
  always_ff @(posedge clk) bus.rom_q <= rom[bus.rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [PHASE_W-1:0] exp_inc(input logic [NOTE_W-1:0] n, input logic [2:0] s);
    return rom[n] >> s;
  endfunction
  function automatic logic [2:0] cur_shift();
`ifdef TONE_OCTAVE_SHIFT_EN
    return bus.req_shift;
`else
    return 3'd0;
`endif
  endfunction
  task automatic set_shift(input logic [2:0] s);
`ifdef TONE_OCTAVE_SHIFT_EN
    bus.req_shift = s;
`else
    if (s != 3'd0) $display("shift %0d ignored in this build", s);
`endif
  endtask
  task automatic cyc();
    logic exp_rdy, exp_vld, acc, pop;
    @(negedge clk);
    exp_rdy = !reset && q.size() < FIFO_DEPTH;
    exp_vld = q.size() > 0 && cyc_n >= q[0].t;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_vld));
    chk("rom_addr", 32'(bus.rom_addr), 32'(last_note));
    if (exp_vld) begin
      chk("rsp_inc", 32'(bus.rsp_inc), 32'(q[0].inc));
      chk("rsp_voice", 32'(bus.rsp_voice), 32'(q[0].voice));
    end
    acc = bus.req_valid && exp_rdy;
    pop = exp_vld && bus.rsp_ready;
    @(posedge clk);
    cyc_n++;
    if (pop) begin
      void'(q.pop_front());
      rsp_seen++;
    end
    if (acc) begin
      q.push_back('{exp_inc(bus.req_note, cur_shift()), bus.req_voice, cyc_n + 2});
      last_note = bus.req_note;
      accepts++;
    end
    #1;
  endtask
  task automatic hit_reset(input int n);
    reset = 1'b1;
    q.delete();
    last_note = '0;
    repeat (n) cyc();
    reset = 1'b0;
  endtask
  task automatic send(input logic [NOTE_W-1:0] note, input logic [VOICE_W-1:0] voice, input logic [2:0] s);
    int a, k;
    a = accepts;
    k = 0;
    bus.req_valid = 1'b1;
    bus.req_note = note;
    bus.req_voice = voice;
    set_shift(s);
    while (accepts == a && k < 50) begin
      cyc();
      k++;
    end
    bus.req_valid = 1'b0;
    chk("send_accepted", 32'(accepts != a), 32'd1);
  endtask
  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (8) cyc();
    chk("drained", 32'(q.size()), 32'd0);
  endtask
  initial begin
    int a, r, idx;
    logic [NOTE_W-1:0] bp_note [6];
    for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
    bus.req_valid = 1'b1;
    bus.req_note = 8'd77;
    bus.req_voice = 5'd9;
    bus.rsp_ready = 1'b1;
    set_shift(3'd0);
    #2;
    hit_reset(5);
    chk("reset_no_fifo_write", 32'(rsp_seen), 32'd0);
    bus.req_valid = 1'b0;
    drain();
    r = rsp_seen;
    send(8'd69, 5'd3, 3'd0);
    repeat (6) cyc();
    chk("single_rsp_pulses", 32'(rsp_seen - r), 32'd1);
    r = rsp_seen;
    for (int n = 0; n < 256; n++) begin
      bus.req_valid = 1'b1;
      bus.req_note = n[7:0];
      bus.req_voice = n[4:0];
      chk("stream_ready", 32'(bus.req_ready), 32'd1);
      cyc();
    end
    drain();
    chk("stream_rsp_count", 32'(rsp_seen - r), 32'd256);
    for (int i = 0; i < 6; i++) bp_note[i] = 8'($urandom);
    bus.rsp_ready = 1'b0;
    a = accepts;
    r = rsp_seen;
    idx = 0;
    bus.req_valid = 1'b1;
    repeat (6) begin
      bus.req_note = bp_note[idx];
      bus.req_voice = 5'(idx);
      cyc();
      if (accepts != a + idx) idx++;
    end
    chk("bp_accepted", 32'(accepts - a), 32'd4);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      bus.req_note = bp_note[idx];
      bus.req_voice = 5'(idx);
      cyc();
      if (accepts != a + idx) idx++;
    end
    drain();
    chk("bp_rsp_count", 32'(rsp_seen - r), 32'd6);
    r = rsp_seen;
    bus.req_valid = 1'b1;
    bus.req_note = 8'd10;
    bus.req_voice = 5'd1;
    cyc();
    bus.req_note = 8'd11;
    bus.req_voice = 5'd2;
    cyc();
    bus.req_valid = 1'b0;
    hit_reset(1);
    repeat (6) cyc();
    chk("midflight_no_rsp", 32'(rsp_seen - r), 32'd0);
    send(8'd12, 5'd4, 3'd0);
    drain();
    chk("post_reset_rsp", 32'(rsp_seen - r), 32'd1);
`ifdef TONE_OCTAVE_SHIFT_EN
    send(8'd69, 5'd6, 3'd2);
    drain();
    send(8'd69, 5'd7, 3'd0);
    drain();
`endif
    r = rsp_seen;
    a = accepts;
    repeat (400) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_note = 8'($urandom);
      bus.req_voice = 5'($urandom);
      set_shift(cur_shift() == 3'd0 ? 3'd0 : 3'd0);
`ifdef TONE_OCTAVE_SHIFT_EN
      bus.req_shift = 3'($urandom);
`endif
      bus.rsp_ready = $urandom_range(0, 9) < 7;
      cyc();
    end
    drain();
    chk("random_all_returned", 32'(rsp_seen - r), 32'(accepts - a));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
